// File: rtl/lsu_mw_if.sv
// Data-bus interface between the memory-writeback load/store unit and the
// data memory. The LSU is the master: it raises dbus_req with a stable
// address/write payload and holds it until the slave answers with dbus_ack.
interface lsu_mw_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/lsu_mw.sv
// Load/store unit for the memory-writeback stage.
// Issues one req/ack data-bus transaction per legal memory instruction,
// stalls the pipeline while the transaction is open, returns extended load
// data for writeback, and flags misaligned/illegal accesses and bus timeouts.
module lsu_mw #(
  parameter int unsigned TIMEOUT = 255   // max REQ cycles without ack (1..255)
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic [4:0]  mem_op_mw,    // [4]=load [3]=store [2:0]=funct3
  input  logic [31:0] addr_mw,
  input  logic [31:0] data_wr_mw,
  output logic        stall_mw,
  output logic [31:0] ld_data_mw,
  output logic        ld_valid_mw,
  output logic        misalign_mw,
  output logic        bus_err_mw,
  lsu_mw_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // The counter holds the number of REQ cycles already spent without ack, so
  // the cycle that sees CNT_LAST is the TIMEOUT-th REQ cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  to_cnt;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;

  // Decode of the instruction currently held in the DE/MW register.
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic        access;
  logic        bad_funct3;
  logic        misaligned;
  logic        go;
  logic [3:0]  wstrb_next;
  logic [31:0] wdata_next;
  logic [31:0] ld_ext;

  assign is_load  = mem_op_mw[4];
  assign is_store = mem_op_mw[3];
  assign funct3   = mem_op_mw[2:0];
  assign access   = is_load ^ is_store;

  // Size is funct3[1:0]; 011 and 11x have no legal meaning.
  assign bad_funct3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  assign misaligned = ((funct3[1:0] == 2'b01) && addr_mw[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr_mw[1:0] != 2'b00));
  assign go = access && !bad_funct3 && !misaligned;

  // Pipeline-facing combinational flags, forced low while reset is held.
  assign misalign_mw = rst && (state == S_IDLE) &&
                       ((is_load && is_store) ||
                        (access && (bad_funct3 || misaligned)));
  assign stall_mw    = rst && (((state == S_IDLE) && go) || (state == S_REQ));

  // Store lane steering: replicate the data and enable only the addressed lanes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    wstrb_next = 4'b0000;
    wdata_next = data_wr_mw;
    case (funct3[1:0])
      2'b00: begin
        wstrb_next = 4'b0001 << addr_mw[1:0];
        wdata_next = {4{data_wr_mw[7:0]}};
      end
      2'b01: begin
        wstrb_next = addr_mw[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{data_wr_mw[15:0]}};
      end
      2'b10: begin
        wstrb_next = 4'b1111;
        wdata_next = data_wr_mw;
      end
      default: begin
        wstrb_next = 4'b0000;
        wdata_next = data_wr_mw;
      end
    endcase
  end

  // Load lane selection and sign/zero extension from the captured size/offset.
  always_comb begin
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    rd_byte = 8'h00;
    rd_half = 16'h0000;
    ld_ext  = bus.dbus_rdata;
    case (offset_q)
      2'd0:    rd_byte = bus.dbus_rdata[7:0];
      2'd1:    rd_byte = bus.dbus_rdata[15:8];
      2'd2:    rd_byte = bus.dbus_rdata[23:16];
      default: rd_byte = bus.dbus_rdata[31:24];
    endcase
    rd_half = offset_q[1] ? bus.dbus_rdata[31:16] : bus.dbus_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_ext = {24'h000000, rd_byte};
      3'b101:  ld_ext = {16'h0000, rd_half};
      default: ld_ext = bus.dbus_rdata;
    endcase
  end

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, and the async
    // reset clears every register here, so dbus_req drops the moment rst falls.
    if (!rst) begin
      state          <= S_IDLE;
      to_cnt         <= 8'd0;
      is_load_q      <= 1'b0;
      funct3_q       <= 3'b000;
      offset_q       <= 2'b00;
      bus.dbus_req   <= 1'b0;
      bus.dbus_we    <= 1'b0;
      bus.dbus_addr  <= 32'h0;
      bus.dbus_wdata <= 32'h0;
      bus.dbus_wstrb <= 4'b0000;
      ld_data_mw     <= 32'h0;
      ld_valid_mw    <= 1'b0;
      bus_err_mw     <= 1'b0;
    end else begin
      ld_valid_mw <= 1'b0;
      bus_err_mw  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state          <= S_REQ;
            to_cnt         <= 8'd0;
            is_load_q      <= is_load;
            funct3_q       <= funct3;
            offset_q       <= addr_mw[1:0];
            bus.dbus_req   <= 1'b1;
            bus.dbus_we    <= is_store;
            bus.dbus_addr  <= {addr_mw[31:2], 2'b00};
            bus.dbus_wdata <= is_store ? wdata_next : 32'h0;
            bus.dbus_wstrb <= is_store ? wstrb_next : 4'b0000;
          end
        end
        S_REQ: begin
          // An ack on the final allowed cycle still completes the access.
          if (bus.dbus_ack) begin
            state          <= S_DONE;
            bus.dbus_req   <= 1'b0;
            bus.dbus_we    <= 1'b0;
            bus.dbus_wstrb <= 4'b0000;
            if (is_load_q) begin
              ld_data_mw  <= ld_ext;
              ld_valid_mw <= 1'b1;
            end
          end else if (to_cnt == CNT_LAST) begin
            state          <= S_ERR;
            bus.dbus_req   <= 1'b0;
            bus.dbus_we    <= 1'b0;
            bus.dbus_wstrb <= 4'b0000;
            bus_err_mw     <= 1'b1;
            ld_data_mw     <= 32'h0;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mw.sv
// Self-checking bench for lsu_mw: directed scenarios plus randomized accesses
// checked against a behavioural model of the load/store rules.
module tb_lsu_mw;
  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_op_mw;
  logic [31:0] addr_mw;
  logic [31:0] data_wr_mw;
  logic        stall_mw;
  logic [31:0] ld_data_mw;
  logic        ld_valid_mw;
  logic        misalign_mw;
  logic        bus_err_mw;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_ld = 32'h0;   // model of the held load result

  lsu_mw_if bus_if ();

  lsu_mw #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_op_mw   (mem_op_mw),
    .addr_mw     (addr_mw),
    .data_wr_mw  (data_wr_mw),
    .stall_mw    (stall_mw),
    .ld_data_mw  (ld_data_mw),
    .ld_valid_mw (ld_valid_mw),
    .misalign_mw (misalign_mw),
    .bus_err_mw  (bus_err_mw),
    .bus         (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full transaction: applies one instruction at posedge+1, answers the bus
  // with ack on REQ cycle ack_cycle (0 = never), checks every phase.
  task automatic do_access(input string tag, input logic [4:0] op,
                           input logic [31:0] addr, input logic [31:0] d,
                           input int ack_cycle, input logic [31:0] rd);
    logic ld, st, ill, mis, acc, go, fin, ok;
    logic [1:0] sz, off;
    logic [3:0] exp_strb;
    logic [31:0] exp_wdata, exp_ld, lane;
    int n;
    ld  = op[4];
    st  = op[3];
    acc = ld ^ st;
    sz  = op[1:0];
    off = addr[1:0];
    ill = (op[2:0] == 3'd3) || (op[2:0] >= 3'd6);
    mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && off != 2'd0);
    go  = acc && !ill && !mis;
    // Expected store payload.
    if (sz == 2'd0) begin
      exp_strb  = 4'(1 << off);
      exp_wdata = (d & 32'hFF) * 32'h01010101;
    end else if (sz == 2'd1) begin
      exp_strb  = addr[1] ? 4'hC : 4'h3;
      exp_wdata = (d & 32'hFFFF) * 32'h00010001;
    end else begin
      exp_strb  = 4'hF;
      exp_wdata = d;
    end
    // Expected load result.
    if (sz == 2'd0) begin
      lane = (rd >> (8 * off)) & 32'hFF;
      exp_ld = (!op[2] && lane >= 32'h80) ? (lane | 32'hFFFFFF00) : lane;
    end else if (sz == 2'd1) begin
      lane = (rd >> (16 * addr[1])) & 32'hFFFF;
      exp_ld = (!op[2] && lane >= 32'h8000) ? (lane | 32'hFFFF0000) : lane;
    end else begin
      exp_ld = rd;
    end

    mem_op_mw  = op;
    addr_mw    = addr;
    data_wr_mw = d;
    bus_if.dbus_ack = 1'b0;
    #3;
    checks++;
    if (stall_mw !== go) begin
      errors++; $display("FAIL %s idle_stall: got %b want %b", tag, stall_mw, go);
    end
    checks++;
    if (misalign_mw !== ((ld && st) || (acc && !go))) begin
      errors++; $display("FAIL %s misalign: got %b want %b", tag, misalign_mw, (ld && st) || (acc && !go));
    end
    checks++;
    if (bus_if.dbus_req !== 1'b0) begin
      errors++; $display("FAIL %s idle_req: got %b want 0", tag, bus_if.dbus_req);
    end
    @(posedge clk); #1;
    if (!go) begin
      checks++;
      if (bus_if.dbus_req !== 1'b0 || stall_mw !== 1'b0) begin
        errors++; $display("FAIL %s no_bus: req %b stall %b want 0 0", tag, bus_if.dbus_req, stall_mw);
      end
      mem_op_mw = 5'd0;
      return;
    end

    n = 0; fin = 1'b0; ok = 1'b0;
    while (!fin) begin
      n++;
      checks++;
      if (bus_if.dbus_req !== 1'b1 || stall_mw !== 1'b1) begin
        errors++; $display("FAIL %s req_phase%0d: req %b stall %b want 1 1", tag, n, bus_if.dbus_req, stall_mw);
      end
      checks++;
      if (bus_if.dbus_addr !== {addr[31:2], 2'b00} || bus_if.dbus_we !== st) begin
        errors++; $display("FAIL %s req_addr: addr %h we %b want %h %b", tag, bus_if.dbus_addr, bus_if.dbus_we, {addr[31:2], 2'b00}, st);
      end
      checks++;
      if (bus_if.dbus_wstrb !== (st ? exp_strb : 4'h0)) begin
        errors++; $display("FAIL %s wstrb: got %b want %b", tag, bus_if.dbus_wstrb, st ? exp_strb : 4'h0);
      end
      if (st) begin
        checks++;
        if (bus_if.dbus_wdata !== exp_wdata) begin
          errors++; $display("FAIL %s wdata: got %h want %h", tag, bus_if.dbus_wdata, exp_wdata);
        end
      end
      if (n == ack_cycle) begin
        bus_if.dbus_ack   = 1'b1;
        bus_if.dbus_rdata = rd;
      end
      @(posedge clk); #1;
      bus_if.dbus_ack = 1'b0;
      if (n == ack_cycle) begin fin = 1'b1; ok = 1'b1; end
      else if (n == TO) fin = 1'b1;
    end

    // DONE or ERR cycle.
    if (ok && ld) last_ld = exp_ld;
    if (!ok) last_ld = 32'h0;
    checks++;
    if (stall_mw !== 1'b0 || bus_if.dbus_req !== 1'b0) begin
      errors++; $display("FAIL %s end_stall: stall %b req %b want 0 0", tag, stall_mw, bus_if.dbus_req);
    end
    checks++;
    if (ld_valid_mw !== (ok && ld) || bus_err_mw !== !ok) begin
      errors++; $display("FAIL %s end_flags: valid %b err %b want %b %b", tag, ld_valid_mw, bus_err_mw, ok && ld, !ok);
    end
    checks++;
    if (ld_data_mw !== last_ld) begin
      errors++; $display("FAIL %s ld_data: got %h want %h", tag, ld_data_mw, last_ld);
    end
    @(posedge clk); #1;
    mem_op_mw = 5'd0;
    checks++;
    if (ld_valid_mw !== 1'b0 || bus_err_mw !== 1'b0 || bus_if.dbus_req !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: valid %b err %b req %b want 0 0 0", tag, ld_valid_mw, bus_err_mw, bus_if.dbus_req);
    end
    checks++;
    if (ld_data_mw !== last_ld) begin
      errors++; $display("FAIL %s ld_hold: got %h want %h", tag, ld_data_mw, last_ld);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_op_mw = 5'd0; addr_mw = 32'h0; data_wr_mw = 32'h0;
    bus_if.dbus_ack = 1'b0; bus_if.dbus_rdata = 32'h0;
    #12;
    checks++;
    if ({stall_mw, ld_valid_mw, misalign_mw, bus_err_mw, bus_if.dbus_req, bus_if.dbus_we} !== 6'b0 ||
        ld_data_mw !== 32'h0 || bus_if.dbus_addr !== 32'h0 || bus_if.dbus_wdata !== 32'h0 ||
        bus_if.dbus_wstrb !== 4'h0) begin
      errors++; $display("FAIL reset_outputs: flags %b%b%b%b%b%b ld %h want all zero", stall_mw, ld_valid_mw,
                         misalign_mw, bus_err_mw, bus_if.dbus_req, bus_if.dbus_we, ld_data_mw);
    end
    rst = 1'b1;
    last_ld = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_access("lw_100",   5'b10010, 32'h100, 32'h0,        3, 32'hDEADBEEF);
    do_access("sb_203",   5'b01000, 32'h203, 32'h000000A5, 1, 32'h0);
    do_access("lb_1",     5'b10000, 32'h001, 32'h0,        1, 32'h00008000);
    do_access("lbu_1",    5'b10100, 32'h001, 32'h0,        1, 32'h00008000);
    do_access("lh_2",     5'b10001, 32'h002, 32'h0,        2, 32'h80010000);
    do_access("lw_102",   5'b10010, 32'h102, 32'h0,        1, 32'h0);
    do_access("both_set", 5'b11010, 32'h100, 32'h0,        1, 32'h0);
    do_access("bad_f3",   5'b10011, 32'h100, 32'h0,        1, 32'h0);
    do_access("sh_6",     5'b01001, 32'h006, 32'h1234BEEF, 2, 32'h0);
  endtask

  task automatic test_timeout();
    do_access("sw_timeout", 5'b01010, 32'h40, 32'hCAFEF00D, 0,  32'h0);
    do_access("sw_lastack", 5'b01010, 32'h44, 32'h01234567, TO, 32'h0);
    do_access("lw_timeout", 5'b10010, 32'h48, 32'h0,        0,  32'h0);
  endtask

  task automatic test_stray_ack();
    bus_if.dbus_ack = 1'b1;
    bus_if.dbus_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_if.dbus_ack = 1'b0;
    checks++;
    if (ld_valid_mw !== 1'b0 || bus_if.dbus_req !== 1'b0 || ld_data_mw !== last_ld) begin
      errors++; $display("FAIL stray_ack: valid %b req %b ld %h want 0 0 %h", ld_valid_mw, bus_if.dbus_req, ld_data_mw, last_ld);
    end
  endtask

  task automatic test_reset_mid_req();
    mem_op_mw = 5'b01010; addr_mw = 32'h80; data_wr_mw = 32'h11223344;
    @(posedge clk); #1;
    checks++;
    if (bus_if.dbus_req !== 1'b1) begin
      errors++; $display("FAIL rst_req_entry: req %b want 1", bus_if.dbus_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus_if.dbus_req !== 1'b0 || stall_mw !== 1'b0) begin
      errors++; $display("FAIL rst_async_drop: req %b stall %b want 0 0", bus_if.dbus_req, stall_mw);
    end
    mem_op_mw = 5'd0;
    last_ld = 32'h0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_if.dbus_req !== 1'b0 || stall_mw !== 1'b0 || ld_data_mw !== 32'h0) begin
      errors++; $display("FAIL rst_post_idle: req %b stall %b ld %h want 0 0 0", bus_if.dbus_req, stall_mw, ld_data_mw);
    end
    do_access("post_rst_lw", 5'b10010, 32'h84, 32'h0, 1, 32'h0BADF00D);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [4:0] op;
      logic [2:0] f3;
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 3));
      f3   = 3'($urandom_range(0, 7));
      if (kind == 2'b01 && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
      op = {kind, f3};
      do_access($sformatf("rnd%0d", i), op, $urandom, $urandom,
                $urandom_range(0, TO), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_stray_ack();
    test_reset_mid_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
